// File: rtl/sprite_pkg.sv
// Shared wr_data field layout and the sprite descriptor record used by the
// multi-sprite address generator and its per-slot hit detectors.
package sprite_pkg;

  localparam int X_MSB     = 31;
  localparam int X_LSB     = 22;
  localparam int Y_MSB     = 21;
  localparam int Y_LSB     = 13;
  localparam int OFF_MSB   = 12;
  localparam int OFF_LSB   = 5;
  localparam int HFLIP_BIT = 4;
  localparam int VFLIP_BIT = 3;
  localparam int EN_BIT    = 0;

  localparam int DESC_X_W   = X_MSB - X_LSB + 1;
  localparam int DESC_Y_W   = Y_MSB - Y_LSB + 1;
  localparam int DESC_OFF_W = OFF_MSB - OFF_LSB + 1;

  typedef struct packed {
    logic [DESC_X_W-1:0]   x;
    logic [DESC_Y_W-1:0]   y;
    logic [DESC_OFF_W-1:0] offset;
    logic                  hflip;
    logic                  vflip;
    logic                  en;
  } sprite_desc_t;

  // Bits [2:1] of the write word are reserved and dropped here.
  function automatic sprite_desc_t unpack_desc(input logic [31:0] d);
    sprite_desc_t r;
    r.x      = d[X_MSB:X_LSB];
    r.y      = d[Y_MSB:Y_LSB];
    r.offset = d[OFF_MSB:OFF_LSB];
    r.hflip  = d[HFLIP_BIT];
    r.vflip  = d[VFLIP_BIT];
    r.en     = d[EN_BIT];
    return r;
  endfunction

endpackage

// File: rtl/sprite_multi_address_gen_if.sv
// Pixel-scan, descriptor-write and address-output bundle between the pixel
// counter, the sprite address generator and the sprite memory.
interface sprite_multi_address_gen_if #(
  parameter int N_SPRITES    = 4,
  parameter int SIZE_X       = 10,
  parameter int SIZE_Y       = 9,
  parameter int SIZE_ADDRESS = 17
);
  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  logic [SIZE_X-1:0]       pixel_x;
  logic [SIZE_Y-1:0]       pixel_y;
  logic                    sprite_on;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_index;
  logic [31:0]             wr_data;
  logic [SIZE_ADDRESS-1:0] memory_address;
  logic                    addr_valid;
  logic [IDX_W-1:0]        sprite_index;
  logic                    count_finished;

  modport master (
    output pixel_x, pixel_y, sprite_on, wr_en, wr_index, wr_data,
    input  memory_address, addr_valid, sprite_index, count_finished
  );

  modport slave (
    input  pixel_x, pixel_y, sprite_on, wr_en, wr_index, wr_data,
    output memory_address, addr_valid, sprite_index, count_finished
  );
endinterface

// File: rtl/sprite_hit_detector.sv
// Combinational coverage test of one pixel against one sprite descriptor,
// returning the unflipped column/row inside the sprite.
module sprite_hit_detector
  import sprite_pkg::*;
#(
  parameter int SIZE_X   = 10,
  parameter int SIZE_Y   = 9,
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 20,
  parameter int COL_W    = $clog2(SPRITE_W),
  parameter int ROW_W    = $clog2(SPRITE_H)
) (
  input  sprite_desc_t      i_desc,
  input  logic [SIZE_X-1:0] i_pixel_x,
  input  logic [SIZE_Y-1:0] i_pixel_y,
  input  logic              i_sprite_on,
  output logic              o_hit,
  output logic [COL_W-1:0]  o_col,
  output logic [ROW_W-1:0]  o_row
);

  // One extra bit so a sprite hanging past the field edge never wraps to 0.
  logic [SIZE_X:0] w_px, w_x0, w_x1;
  logic [SIZE_Y:0] w_py, w_y0, w_y1;

  always_comb begin
    w_px  = (SIZE_X+1)'(i_pixel_x);
    w_x0  = (SIZE_X+1)'(i_desc.x);
    w_x1  = w_x0 + (SIZE_X+1)'(SPRITE_W);
    w_py  = (SIZE_Y+1)'(i_pixel_y);
    w_y0  = (SIZE_Y+1)'(i_desc.y);
    w_y1  = w_y0 + (SIZE_Y+1)'(SPRITE_H);
    o_hit = i_desc.en & i_sprite_on &
            (w_px >= w_x0) & (w_px < w_x1) &
            (w_py >= w_y0) & (w_py < w_y1);
    o_col = COL_W'(w_px - w_x0);
    o_row = ROW_W'(w_py - w_y0);
  end

endmodule

// File: rtl/sprite_multi_address_gen.sv
// Multi-slot sprite address generator: descriptor table, priority select with
// flip, and a two-stage pipeline producing the sprite-memory address per pixel.
module sprite_multi_address_gen
  import sprite_pkg::*;
#(
  parameter int N_SPRITES    = 4,
  parameter int SIZE_X       = 10,
  parameter int SIZE_Y       = 9,
  parameter int OFFSET_W     = 8,
  parameter int SPRITE_W     = 20,
  parameter int SPRITE_H     = 20,
  parameter int SIZE_ADDRESS = 17
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  sprite_multi_address_gen_if.slave  bus
);

  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  if ((2**OFFSET_W) * SPRITE_W * SPRITE_H > 2**SIZE_ADDRESS) begin : g_addr_chk
    $error("sprite_multi_address_gen: SIZE_ADDRESS too small for all sprite images");
  end
  if (SIZE_X != DESC_X_W || SIZE_Y != DESC_Y_W || OFFSET_W != DESC_OFF_W) begin : g_fmt_chk
    $error("sprite_multi_address_gen: field widths disagree with the wr_data layout");
  end

  sprite_desc_t     r_desc [N_SPRITES];
  logic             w_hit  [N_SPRITES];
  logic [COL_W-1:0] w_col  [N_SPRITES];
  logic [ROW_W-1:0] w_row  [N_SPRITES];

  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SPRITES; i++) r_desc[i] <= '0;
    end else if (bus.wr_en && (32'(bus.wr_index) < N_SPRITES)) begin
      r_desc[bus.wr_index] <= unpack_desc(bus.wr_data);
    end
  end

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_slot
    sprite_hit_detector #(
      .SIZE_X(SIZE_X), .SIZE_Y(SIZE_Y), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
      .COL_W(COL_W), .ROW_W(ROW_W)
    ) u_hit (
      .i_desc(r_desc[g]), .i_pixel_x(bus.pixel_x), .i_pixel_y(bus.pixel_y),
      .i_sprite_on(bus.sprite_on), .o_hit(w_hit[g]), .o_col(w_col[g]), .o_row(w_row[g])
    );
  end

  logic             w_win, w_last;
  logic [IDX_W-1:0] w_sel;
  logic [COL_W-1:0] w_col_f;
  logic [ROW_W-1:0] w_row_f;

  always_comb begin
    w_win = 1'b0;
    w_sel = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_win = 1'b1;
        w_sel = IDX_W'(i);
      end
    end
    w_last  = (w_col[w_sel] == COL_W'(SPRITE_W - 1)) && (w_row[w_sel] == ROW_W'(SPRITE_H - 1));
    w_col_f = r_desc[w_sel].hflip ? COL_W'(SPRITE_W - 1) - w_col[w_sel] : w_col[w_sel];
    w_row_f = r_desc[w_sel].vflip ? ROW_W'(SPRITE_H - 1) - w_row[w_sel] : w_row[w_sel];
  end

  logic                r_vld_p1, r_last_p1;
  logic [IDX_W-1:0]    r_idx_p1;
  logic [COL_W-1:0]    r_col_p1;
  logic [ROW_W-1:0]    r_row_p1;
  logic [OFFSET_W-1:0] r_off_p1;
  logic [31:0]         w_addr_full;

  // Stage 1: winning slot and its flipped in-sprite coordinates
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_idx_p1  <= '0;
      r_col_p1  <= '0;
      r_row_p1  <= '0;
      r_off_p1  <= '0;
    end else begin
      r_vld_p1  <= w_win;
      r_last_p1 <= w_win & w_last;
      r_idx_p1  <= w_win ? w_sel : '0;
      r_col_p1  <= w_win ? w_col_f : '0;
      r_row_p1  <= w_win ? w_row_f : '0;
      r_off_p1  <= w_win ? r_desc[w_sel].offset : '0;
    end
  end

  assign w_addr_full = 32'(r_off_p1) * 32'(SPRITE_W * SPRITE_H)
                     + 32'(r_row_p1) * 32'(SPRITE_W) + 32'(r_col_p1);

  // Stage 2: linear sprite-memory address
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      bus.addr_valid     <= 1'b0;
      bus.memory_address <= '0;
      bus.sprite_index   <= '0;
      bus.count_finished <= 1'b0;
    end else begin
      bus.addr_valid     <= r_vld_p1;
      bus.memory_address <= r_vld_p1 ? SIZE_ADDRESS'(w_addr_full) : '0;
      bus.sprite_index   <= r_vld_p1 ? r_idx_p1 : '0;
      bus.count_finished <= r_last_p1;
    end
  end

endmodule

// File: tb/tb_sprite_multi_address_gen.sv
// Directed plus randomized bench for sprite_multi_address_gen against a
// pixel-level reference model of sprite coverage and address arithmetic.
module tb_sprite_multi_address_gen;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b0;

  sprite_multi_address_gen_if bus ();

  sprite_multi_address_gen dut (
    .clk_pixel(clk_pixel),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #20 clk_pixel = ~clk_pixel;

  typedef struct {
    int x, y, off;
    bit h, v, en;
  } mdesc_t;

  typedef struct {
    bit vld;
    int addr;
    int idx;
    bit fin;
  } exp_t;

  mdesc_t md [4];
  exp_t   q  [$];
  int     n_cmp = 0;
  int     n_err = 0;

  function automatic logic [31:0] pack(int x, int y, int off, bit h, bit v, bit en);
    return {10'(x), 9'(y), 8'(off), h, v, 2'b00, en};
  endfunction

  function automatic mdesc_t unpack(logic [31:0] w);
    mdesc_t d;
    d.x = int'(w[31:22]); d.y = int'(w[21:13]); d.off = int'(w[12:5]);
    d.h = w[4]; d.v = w[3]; d.en = w[0];
    return d;
  endfunction

  // First enabled sprite (lowest slot) covering the pixel decides the address.
  function automatic exp_t model(int px, int py, bit on);
    exp_t e = '{0, 0, 0, 0};
    if (!on) return e;
    for (int s = 0; s < 4; s++) begin
      if (md[s].en && px >= md[s].x && px < md[s].x + 20 &&
          py >= md[s].y && py < md[s].y + 20) begin
        int col = px - md[s].x;
        int row = py - md[s].y;
        e.fin  = (col == 19) && (row == 19);
        if (md[s].h) col = 19 - col;
        if (md[s].v) row = 19 - row;
        e.vld  = 1;
        e.idx  = s;
        e.addr = (md[s].off * 400 + row * 20 + col) % (1 << 17);
        return e;
      end
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, int exp);
    n_cmp++;
    assert (got === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic outs(string tag, bit vld, int addr, int idx, bit fin);
    chk({tag, ".valid"}, 32'(bus.addr_valid), int'(vld));
    chk({tag, ".addr"},  32'(bus.memory_address), addr);
    chk({tag, ".index"}, 32'(bus.sprite_index), idx);
    chk({tag, ".finished"}, 32'(bus.count_finished), int'(fin));
  endtask

  task automatic step(int px, int py, bit on, bit we = 0, int widx = 0, logic [31:0] wd = '0);
    exp_t e;
    @(negedge clk_pixel);
    bus.pixel_x   = 10'(px);
    bus.pixel_y   = 9'(py);
    bus.sprite_on = on;
    bus.wr_en     = we;
    bus.wr_index  = 2'(widx);
    bus.wr_data   = wd;
    q.push_back(model(px, py, on));
    if (we && widx < 4) md[widx] = unpack(wd);
    @(posedge clk_pixel);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      outs("pipe", e.vld, e.addr, e.idx, e.fin);
    end
  endtask

  task automatic wr(int idx, int x, int y, int off, bit h, bit v, bit en);
    step(0, 0, 0, 1, idx, pack(x, y, off, h, v, en));
  endtask

  task automatic restart_model();
    for (int s = 0; s < 4; s++) md[s] = '{0, 0, 0, 0, 0, 0};
    q.delete();
    q.push_back('{0, 0, 0, 0});
  endtask

  initial begin
    bus.pixel_x = '0; bus.pixel_y = '0; bus.sprite_on = 1'b0;
    bus.wr_en = 1'b0; bus.wr_index = '0; bus.wr_data = '0;
    restart_model();
    repeat (3) @(posedge clk_pixel);
    #1;
    outs("reset", 0, 0, 0, 0);
    @(negedge clk_pixel);
    reset = 1'b1;

    wr(0, 32, 32, 8, 0, 0, 1);
    step(32, 32, 1);
    step(0, 0, 0);
    outs("t1_origin", 1, 3200, 0, 0);

    step(51, 51, 1);
    step(52, 51, 1);
    outs("t2_last", 1, 3599, 0, 1);
    step(0, 0, 0);
    outs("t2_outside", 0, 0, 0, 0);

    wr(1, 40, 32, 1, 0, 0, 1);
    step(45, 33, 1);
    step(0, 0, 0);
    outs("t3_prio", 1, 3233, 0, 0);
    wr(0, 32, 32, 8, 0, 0, 0);
    step(45, 33, 1);
    step(0, 0, 0);
    outs("t3_slot1", 1, 425, 1, 0);

    wr(0, 32, 32, 8, 1, 0, 1);
    step(32, 32, 1);
    step(0, 0, 0);
    outs("t4_hflip", 1, 3219, 0, 0);
    wr(0, 32, 32, 8, 1, 1, 1);
    step(32, 32, 1);
    step(51, 51, 1);
    outs("t4_hvflip", 1, 3599, 0, 0);
    step(0, 0, 0);
    outs("t4_hvlast", 1, 3200, 0, 1);

    wr(2, 1015, 500, 3, 0, 0, 1);
    step(1020, 505, 1);
    step(3, 505, 1);
    outs("t5_edge", 1, 1305, 2, 0);
    step(0, 0, 0);
    outs("t5_nowrap", 0, 0, 0, 0);

    for (int n = 0; n < 1500; n++) begin
      int s  = int'($urandom_range(0, 3));
      int px = (md[s].x + int'($urandom_range(0, 25)) - 3 + 1024) % 1024;
      int py = (md[s].y + int'($urandom_range(0, 25)) - 3 + 512) % 512;
      bit on = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0)
        step(px, py, on, 1, int'($urandom_range(0, 3)),
             pack(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0)));
      else
        step(px, py, on);
    end

    wr(0, 32, 32, 8, 0, 0, 1);
    step(32, 32, 1);
    step(33, 32, 1);
    #5;
    reset = 1'b0;
    #1;
    outs("t6_async", 0, 0, 0, 0);
    @(negedge clk_pixel);
    reset = 1'b1;
    restart_model();
    step(32, 32, 1);
    step(33, 32, 1);
    step(34, 32, 1);
    outs("t6_cleared", 0, 0, 0, 0);
    wr(0, 32, 32, 8, 0, 0, 1);
    step(33, 32, 1);
    step(0, 0, 0);
    outs("t6_rewrite", 1, 3201, 0, 0);
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
